// File: rtl/bcd_key_sequencer.sv
// bcd_key_sequencer: keypad-entry front end that builds BCD operands and an operation for the ALU,
// then captures its result for display. Optional macro ENTRY_CHAIN_EN: operator key in ENTRY_B evaluates and chains.
module bcd_key_sequencer #(
    parameter int DIGIT_NUM = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [4:0]             key_code,
    output logic                   key_ready,
    output logic [4*DIGIT_NUM-1:0] operand0,
    output logic                   operand0_sign,
    output logic [4*DIGIT_NUM-1:0] operand1,
    output logic                   operand1_sign,
    output logic [2:0]             operation,
    output logic                   alu_busy,
    input  logic [4*DIGIT_NUM-1:0] result,
    input  logic                   result_sign,
    input  logic                   flag_ov,
    output logic [4*DIGIT_NUM-1:0] disp_value,
    output logic                   disp_sign,
    output logic                   disp_error,
    output logic [2:0]             dbg_state
);
    localparam int W  = 4 * DIGIT_NUM;
    localparam int CW = $clog2(DIGIT_NUM + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_NUM);
    localparam logic [2:0]    OP_DIV  = 3'd3;

    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'd0,
        ST_OP      = 3'd1,
        ST_ENTRY_B = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    // Handshake: a key is consumed on any rising edge where key_valid && key_ready;
    // key_ready is low only while EXEC, so a strobe in that cycle is dropped.

    state_t        state_q, state_d;
    logic [W-1:0]  operand0_q, operand0_d;
    logic [W-1:0]  operand1_q, operand1_d;
    logic          operand0_sign_q, operand0_sign_d;
    logic          operand1_sign_q, operand1_sign_d;
    logic [2:0]    operation_q, operation_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  disp_value_q, disp_value_d;
    logic          disp_sign_q, disp_sign_d;
    logic          disp_error_q, disp_error_d;
    logic          key_ready_q, key_ready_d;
    logic          alu_busy_q, alu_busy_d;
    logic          chain_q, chain_d;
    logic [2:0]    chain_op_q, chain_op_d;

    logic          key_fire, is_digit, is_op, is_eq, is_clr, is_neg;
    logic [2:0]    key_op;
    logic [3:0]    key_digit;
    logic          cap_sign;

    // Appends one digit at the LSD; leading zeros and digits past the limit are dropped.
    function automatic logic [CW+W-1:0] enter_digit(input logic [W-1:0]  mag,
                                                    input logic [CW-1:0] cnt,
                                                    input logic [3:0]    dig);
        logic [W-1:0]  m;
        logic [CW-1:0] c;
        m = mag;
        c = cnt;
        if (!((mag == '0) && (dig == 4'd0)) && (cnt < CNT_MAX)) begin
            m = {mag[W-5:0], dig};
            c = cnt + 1'b1;
        end
        return {c, m};
    endfunction

    function automatic logic [CW-1:0] sig_digits(input logic [W-1:0] mag);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if (mag[4*i +: 4] != 4'd0) n = CW'(i + 1);
        end
        return n;
    endfunction

    always_comb begin
        key_fire  = key_valid && key_ready_q;
        is_digit  = key_fire && (key_code <= 5'd9);
        is_op     = key_fire && (key_code >= 5'd10) && (key_code <= 5'd14);
        is_eq     = key_fire && (key_code == 5'd15);
        is_clr    = key_fire && (key_code == 5'd16);
        is_neg    = key_fire && (key_code == 5'd17);
        key_op    = 3'(key_code - 5'd10);
        key_digit = key_code[3:0];
        cap_sign  = (result == '0) ? 1'b0 : result_sign;
    end

    always_comb begin
        state_d         = state_q;
        operand0_d      = operand0_q;
        operand1_d      = operand1_q;
        operand0_sign_d = operand0_sign_q;
        operand1_sign_d = operand1_sign_q;
        operation_d     = operation_q;
        cnt_d           = cnt_q;
        disp_value_d    = disp_value_q;
        disp_sign_d     = disp_sign_q;
        disp_error_d    = disp_error_q;
        chain_d         = chain_q;
        chain_op_d      = chain_op_q;

        unique case (state_q)
            ST_ENTRY_A: begin
                if (is_digit) begin
                    {cnt_d, operand0_d} = enter_digit(operand0_q, cnt_q, key_digit);
                end else if (is_neg) begin
                    operand0_sign_d = ~operand0_sign_q;
                end else if (is_op) begin
                    operation_d = key_op;
                    state_d     = ST_OP;
                end
            end
            ST_OP: begin
                if (is_op) begin
                    operation_d = key_op;
                end else if (is_digit) begin
                    operand1_sign_d     = 1'b0;
                    {cnt_d, operand1_d} = enter_digit('0, '0, key_digit);
                    state_d             = ST_ENTRY_B;
                end
            end
            ST_ENTRY_B: begin
                if (is_digit) begin
                    {cnt_d, operand1_d} = enter_digit(operand1_q, cnt_q, key_digit);
                end else if (is_neg) begin
                    operand1_sign_d = ~operand1_sign_q;
                end else if (is_eq) begin
                    state_d = ((operation_q == OP_DIV) && (operand1_q == '0)) ? ST_ERROR : ST_EXEC;
`ifdef ENTRY_CHAIN_EN
                end else if (is_op) begin
                    // Evaluate the pending expression first; the new operator waits in chain_op.
                    if ((operation_q == OP_DIV) && (operand1_q == '0)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d    = ST_EXEC;
                        chain_d    = 1'b1;
                        chain_op_d = key_op;
                    end
`endif
                end
            end
            ST_EXEC: begin
                chain_d = 1'b0;
                if (flag_ov) begin
                    state_d = ST_ERROR;
                end else begin
                    disp_value_d = result;
                    disp_sign_d  = cap_sign;
                    if (chain_q) begin
                        operand0_d      = result;
                        operand0_sign_d = cap_sign;
                        operation_d     = chain_op_q;
                        cnt_d           = sig_digits(result);
                        state_d         = ST_OP;
                    end else begin
                        state_d = ST_SHOW;
                    end
                end
            end
            ST_SHOW: begin
                if (is_digit) begin
                    operand0_sign_d     = 1'b0;
                    {cnt_d, operand0_d} = enter_digit('0, '0, key_digit);
                    state_d             = ST_ENTRY_A;
                end else if (is_op) begin
                    operand0_d      = disp_value_q;
                    operand0_sign_d = disp_sign_q;
                    operation_d     = key_op;
                    cnt_d           = sig_digits(disp_value_q);
                    state_d         = ST_OP;
                end else if (is_neg && (disp_value_q != '0)) begin
                    disp_sign_d     = ~disp_sign_q;
                    operand0_sign_d = ~operand0_sign_q;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ENTRY_A;
            end
        endcase

        // 'C' can never be accepted during EXEC because key_ready is low there.
        if (is_clr) begin
            state_d         = ST_ENTRY_A;
            operand0_d      = '0;
            operand1_d      = '0;
            operand0_sign_d = 1'b0;
            operand1_sign_d = 1'b0;
            operation_d     = 3'd0;
            cnt_d           = '0;
            chain_d         = 1'b0;
            chain_op_d      = 3'd0;
        end

        unique case (state_d)
            ST_ENTRY_A, ST_OP: begin
                disp_value_d = operand0_d;
                disp_sign_d  = operand0_sign_d;
                disp_error_d = 1'b0;
            end
            ST_ENTRY_B: begin
                disp_value_d = operand1_d;
                disp_sign_d  = operand1_sign_d;
                disp_error_d = 1'b0;
            end
            ST_ERROR: begin
                disp_value_d = '0;
                disp_sign_d  = 1'b0;
                disp_error_d = 1'b1;
            end
            default: begin
                disp_error_d = 1'b0;
            end
        endcase

        key_ready_d = (state_d != ST_EXEC);
        alu_busy_d  = (state_d == ST_EXEC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_ENTRY_A;
            operand0_q      <= '0;
            operand1_q      <= '0;
            operand0_sign_q <= 1'b0;
            operand1_sign_q <= 1'b0;
            operation_q     <= 3'd0;
            cnt_q           <= '0;
            disp_value_q    <= '0;
            disp_sign_q     <= 1'b0;
            disp_error_q    <= 1'b0;
            key_ready_q     <= 1'b1;
            alu_busy_q      <= 1'b0;
            chain_q         <= 1'b0;
            chain_op_q      <= 3'd0;
        end else begin
            state_q         <= state_d;
            operand0_q      <= operand0_d;
            operand1_q      <= operand1_d;
            operand0_sign_q <= operand0_sign_d;
            operand1_sign_q <= operand1_sign_d;
            operation_q     <= operation_d;
            cnt_q           <= cnt_d;
            disp_value_q    <= disp_value_d;
            disp_sign_q     <= disp_sign_d;
            disp_error_q    <= disp_error_d;
            key_ready_q     <= key_ready_d;
            alu_busy_q      <= alu_busy_d;
            chain_q         <= chain_d;
            chain_op_q      <= chain_op_d;
        end
    end

    assign key_ready     = key_ready_q;
    assign operand0      = operand0_q;
    assign operand1      = operand1_q;
    assign operand0_sign = operand0_sign_q;
    assign operand1_sign = operand1_sign_q;
    assign operation     = operation_q;
    assign alu_busy      = alu_busy_q;
    assign disp_value    = disp_value_q;
    assign disp_sign     = disp_sign_q;
    assign disp_error    = disp_error_q;
    assign dbg_state     = state_q;

endmodule
